// File: rtl/cmd_frame_decoder.sv
// Decodes 4-byte command frames (A5, addr, data, addr^data) from a byte stream
// into single-cycle register-file writes, rejecting bad or stalled frames.
module cmd_frame_decoder #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  in_ready,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WIDTH-1:0]      wr_data,
    output logic                  frame_err,
    output logic [7:0]            err_count,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        CSUM,
        WRITE
    } state_t;

    localparam logic [WIDTH-1:0] HEADER     = WIDTH'(8'hA5);
    localparam logic [7:0]       IDLE_LIMIT = 8'(TIMEOUT - 1);
    localparam logic [31:0]      DEPTH_U    = 32'(DEPTH);

    state_t                  state_q, state_d;
    logic [WIDTH-1:0]        addr_q, addr_d;
    logic [WIDTH-1:0]        data_q, data_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0]        wr_data_q, wr_data_d;
    logic [7:0]              idle_q, idle_d;
    logic                    frame_err_q, frame_err_d;
    logic [7:0]              err_count_q, err_count_d;

    logic accept;
    logic in_frame;
    logic timeout;
    logic frame_ok;
    logic reject;

    assign accept   = in_valid && in_ready;
    assign in_frame = (state_q == ADDR) || (state_q == DATA) || (state_q == CSUM);
    // The counter holds TIMEOUT-1 on the last tolerated idle cycle, so the next idle edge times out.
    assign timeout  = in_frame && !accept && (idle_q == IDLE_LIMIT);
    assign frame_ok = (in_data == (addr_q ^ data_q)) && (32'(addr_q) < DEPTH_U);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            data_q      <= '0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            idle_q      <= '0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            idle_q      <= idle_d;
            frame_err_q <= frame_err_d;
            err_count_q <= err_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        reject  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept && (in_data == HEADER)) state_d = ADDR;
            end
            ADDR: begin
                if (accept) state_d = DATA;
                else if (timeout) begin
                    state_d = IDLE;
                    reject  = 1'b1;
                end
            end
            DATA: begin
                if (accept) state_d = CSUM;
                else if (timeout) begin
                    state_d = IDLE;
                    reject  = 1'b1;
                end
            end
            CSUM: begin
                if (accept) begin
                    if (frame_ok) state_d = WRITE;
                    else begin
                        state_d = IDLE;
                        reject  = 1'b1;
                    end
                end else if (timeout) begin
                    state_d = IDLE;
                    reject  = 1'b1;
                end
            end
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Write outputs load only on the way into WRITE so they stay put while a new frame is captured.
    always_comb begin
        addr_d      = addr_q;
        data_d      = data_q;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        idle_d      = '0;
        frame_err_d = reject;
        err_count_d = err_count_q;
        if ((state_q == ADDR) && accept) addr_d = in_data;
        if ((state_q == DATA) && accept) data_d = in_data;
        if ((state_q == CSUM) && (state_d == WRITE)) begin
            wr_addr_d = ADDR_WIDTH'(addr_q);
            wr_data_d = data_q;
        end
        if (in_frame && (state_d == state_q)) idle_d = idle_q + 8'd1;
        if (reject && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
    end

    always_comb begin
        in_ready  = (state_q != WRITE);
        busy      = (state_q != IDLE);
        wr_en     = (state_q == WRITE);
        wr_addr   = wr_addr_q;
        wr_data   = wr_data_q;
        frame_err = frame_err_q;
        err_count = err_count_q;
    end

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Scoreboard bench for cmd_frame_decoder: a frame-level reference model queues the
// expected writes and errors, and a negedge monitor matches them against the DUT.
module tb_cmd_frame_decoder;

    localparam int WIDTH      = 8;
    localparam int DEPTH      = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int TIMEOUT    = 255;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic [WIDTH-1:0]      in_data;
    logic                  in_ready;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [WIDTH-1:0]      wr_data;
    logic                  frame_err;
    logic [7:0]            err_count;
    logic                  busy;

    typedef struct {
        logic [3:0] addr;
        logic [7:0] data;
        int         edgeIdx;
    } wrExp_t;

    typedef struct {
        logic [7:0] cnt;
        int         edgeIdx;
    } errExp_t;

    wrExp_t     wrQ[$];
    errExp_t    errQ[$];
    logic [7:0] frameBytes[$];
    int         gap;
    int         modelErrCnt;
    int         cyc;
    int         testsRun;
    int         testsFailed;

    cmd_frame_decoder #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH),
        .ADDR_WIDTH(ADDR_WIDTH),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .frame_err(frame_err),
        .err_count(err_count),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frames are judged as whole byte lists, not by tracking decoder states.
    task automatic modelError(input int e);
        if (modelErrCnt < 255) modelErrCnt++;
        errQ.push_back('{8'(modelErrCnt), e});
    endtask

    task automatic modelAccept(input logic [7:0] b, input int e);
        gap = 0;
        if (frameBytes.size() == 0) begin
            if (b == 8'hA5) frameBytes.push_back(b);
        end else begin
            frameBytes.push_back(b);
            if (frameBytes.size() == 4) begin
                if ((frameBytes[3] == (frameBytes[1] ^ frameBytes[2])) && (int'(frameBytes[1]) < DEPTH))
                    wrQ.push_back('{frameBytes[1][3:0], frameBytes[2], e});
                else
                    modelError(e);
                frameBytes.delete();
            end
        end
    endtask

    task automatic modelIdle(input int e);
        if (frameBytes.size() > 0) begin
            gap++;
            if (gap == TIMEOUT) begin
                modelError(e);
                frameBytes.delete();
                gap = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        logic rdy;
        logic done;
        done     = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        for (int t = 0; t < 8 && !done; t++) begin
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                done = 1'b1;
                modelAccept(b, cyc);
            end else begin
                modelIdle(cyc);
            end
        end
        in_valid = 1'b0;
        if (!done) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL handshake: byte %0h not accepted, in_ready=%0b expected 1", b, in_ready);
        end
    endtask

    task automatic idleCycles(input int n);
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            in_data = 8'($urandom);
            @(posedge clk);
            #1;
            modelIdle(cyc);
        end
    endtask

    task automatic sendFrame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c, input int maxGap);
        applyStimulus(8'hA5);
        idleCycles($urandom_range(maxGap, 0));
        applyStimulus(a);
        idleCycles($urandom_range(maxGap, 0));
        applyStimulus(d);
        idleCycles($urandom_range(maxGap, 0));
        applyStimulus(c);
    endtask

    task automatic doReset();
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        frameBytes.delete();
        gap         = 0;
        modelErrCnt = 0;
        checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_wr_en", 32'(wr_en), 32'd0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset_err_count", 32'(err_count), 32'd0);
        checkOutput("reset_wr_addr", 32'(wr_addr), 32'd0);
        checkOutput("reset_wr_data", 32'(wr_data), 32'd0);
    endtask

    // Monitor: every DUT write or error pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_en && frame_err) checkOutput("wr_en_and_frame_err", 32'd1, 32'd0);
            if (wr_en) begin
                if (wrQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_write: addr=%0h data=%0h, expected no write", wr_addr, wr_data);
                end else begin
                    wrExp_t w;
                    w = wrQ.pop_front();
                    checkOutput("wr_addr", 32'(wr_addr), 32'(w.addr));
                    checkOutput("wr_data", 32'(wr_data), 32'(w.data));
                    checkOutput("wr_latency", 32'(cyc), 32'(w.edgeIdx));
                end
            end
            if (frame_err) begin
                if (errQ.size() == 0) begin
                    testsRun++;
                    testsFailed++;
                    $display("[TB] FAIL unexpected_frame_err: err_count=%0d, expected no error", err_count);
                end else begin
                    errExp_t x;
                    x = errQ.pop_front();
                    checkOutput("err_count", 32'(err_count), 32'(x.cnt));
                    checkOutput("err_timing", 32'(cyc), 32'(x.edgeIdx));
                end
            end
        end
    end

    initial begin
        testsRun    = 0;
        testsFailed = 0;
        cyc         = 0;
        gap         = 0;
        modelErrCnt = 0;
        rst         = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        @(posedge clk);
        #1;
        doReset();

        applyStimulus(8'hA5); applyStimulus(8'h03); applyStimulus(8'h5C); applyStimulus(8'h5F);
        idleCycles(2);
        applyStimulus(8'hA5); applyStimulus(8'h03); applyStimulus(8'h5C); applyStimulus(8'h00);
        idleCycles(2);
        checkOutput("bad_csum_err_count", 32'(err_count), 32'd1);
        applyStimulus(8'hA5); applyStimulus(8'h12); applyStimulus(8'h01); applyStimulus(8'h13);
        idleCycles(2);
        applyStimulus(8'h00); applyStimulus(8'hFF); applyStimulus(8'hA5);
        applyStimulus(8'h0F); applyStimulus(8'hA5); applyStimulus(8'hAA);
        idleCycles(2);

        applyStimulus(8'hA5); applyStimulus(8'h01);
        idleCycles(254);
        checkOutput("gap254_busy", 32'(busy), 32'd1);
        applyStimulus(8'h22); applyStimulus(8'h23);
        idleCycles(2);
        applyStimulus(8'hA5); applyStimulus(8'h01);
        idleCycles(255);
        checkOutput("timeout_busy", 32'(busy), 32'd0);
        applyStimulus(8'hA5); applyStimulus(8'h04); applyStimulus(8'h77); applyStimulus(8'h73);
        idleCycles(2);

        applyStimulus(8'hA5); applyStimulus(8'h02);
        doReset();
        idleCycles(3);
        checkOutput("after_reset_err_count", 32'(err_count), 32'd0);

        for (int f = 0; f < 40; f++) begin
            logic [7:0] a;
            logic [7:0] d;
            int         kind;
            kind = $urandom_range(3, 0);
            d    = 8'($urandom);
            case (kind)
                0: begin
                    a = 8'($urandom_range(DEPTH - 1, 0));
                    sendFrame(a, d, a ^ d, 2);
                end
                1: begin
                    a = 8'($urandom_range(DEPTH - 1, 0));
                    sendFrame(a, d, a ^ d ^ 8'($urandom_range(255, 1)), 2);
                end
                2: begin
                    a = 8'($urandom_range(255, DEPTH));
                    sendFrame(a, d, a ^ d, 2);
                end
                default: begin
                    for (int j = 0; j < 3; j++) applyStimulus(8'($urandom));
                end
            endcase
            idleCycles($urandom_range(2, 0));
        end
        idleCycles(256);

        for (int k = 0; k < 256; k++) sendFrame(8'h00, 8'h00, 8'h01, 0);
        idleCycles(3);
        checkOutput("err_count_saturated", 32'(err_count), 32'd255);
        checkOutput("pending_writes", 32'(wrQ.size()), 32'd0);
        checkOutput("pending_errors", 32'(errQ.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/cmd_frame_decoder.md
CMD_FRAME_DECODER -- requirements
Module: cmd_frame_decoder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: write-data width and byte width of the input stream.
REQ-002 SHALL have parameter DEPTH, default 16: number of addressable target registers.
REQ-003 SHALL have parameter ADDR_WIDTH, default 4: width of wr_addr.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum idle cycles allowed between bytes inside a frame.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on rising edge.
REQ-006 SHALL have port rst, input, 1 bit: one clock; reset is synchronous and active-low.
REQ-007 SHALL have port in_valid, input, 1 bit: the upstream byte on in_data is valid.
REQ-008 SHALL have port in_data, input, WIDTH bits: upstream byte stream.
REQ-009 SHALL have port in_ready, output, 1 bit: decoder can accept a byte this cycle.
REQ-010 SHALL have port wr_en, output, 1 bit: one-cycle register-file write strobe.
REQ-011 SHALL have port wr_addr, output, ADDR_WIDTH bits: target register index.
REQ-012 SHALL have port wr_data, output, WIDTH bits: value to write.
REQ-013 SHALL have port frame_err, output, 1 bit: one-cycle pulse on any frame rejection.
REQ-014 SHALL have port err_count, output, 8 bits: saturating count of rejected frames.
REQ-015 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-016 SHALL treat a byte as accepted only when in_valid=1 and in_ready=1 at the same rising edge.
REQ-017 SHALL use a frame format of four bytes: header 0xA5, address byte, data byte, checksum byte.
REQ-018 SHALL define the checksum as address byte XOR data byte.
REQ-019 SHALL implement states IDLE, ADDR, DATA, CSUM and WRITE.
REQ-020 SHALL, in IDLE, move to ADDR on an accepted 0xA5 and silently discard any other accepted byte.
REQ-021 SHALL, in ADDR, capture the accepted byte and move to DATA.
REQ-022 SHALL, in DATA, capture the accepted byte and move to CSUM.
REQ-023 SHALL, in CSUM, move to WRITE if the checksum matches and the captured address is less than DEPTH; otherwise it SHALL return to IDLE and pulse frame_err.
REQ-024 SHALL, in WRITE, drive wr_en=1 for exactly one cycle, with wr_addr and wr_data holding the captured values, then return to IDLE.
REQ-025 SHALL drive in_ready=1 in IDLE, ADDR, DATA and CSUM, and in_ready=0 in WRITE.
REQ-026 SHALL assert wr_en in the cycle immediately after the cycle in which the checksum byte is accepted (latency 1).
REQ-027 SHALL give the address and data bytes no special meaning: a value of 0xA5 in ADDR or DATA is ordinary data.
REQ-028 SHALL keep an 8-bit idle counter in ADDR, DATA and CSUM, cleared on every accepted byte and on every state entry.
REQ-029 SHALL, when the idle counter reaches TIMEOUT, return to IDLE and pulse frame_err.
REQ-030 SHALL increment err_count on every frame_err pulse and hold it at 255 once reached.
REQ-031 SHALL keep wr_addr and wr_data stable outside WRITE; they hold the last captured values.
REQ-032 SHALL never assert wr_en and frame_err in the same cycle.

Reset
REQ-033 SHALL, when rst=0 at a rising edge, return to IDLE and clear wr_en, wr_addr, wr_data, frame_err, err_count, busy and the idle counter to 0.
REQ-034 SHALL let reset override everything mid-frame: a partial frame is discarded with no wr_en and no frame_err.
REQ-035 SHALL drive in_ready=1 in the first cycle after rst is released.

Verification
REQ-036 SHALL cover: bytes A5,03,5C,5F, each with in_valid=1 -> one wr_en pulse with wr_addr=3 and wr_data=0x5C, one cycle after 5F is accepted.
REQ-037 SHALL cover: bytes A5,03,5C,00 -> frame_err pulse, no wr_en, err_count goes from 0 to 1.
REQ-038 SHALL cover: bytes A5,12,01,13 with DEPTH=16 -> address out of range, frame_err pulse, no wr_en.
REQ-039 SHALL cover: bytes 00,FF,A5,0F,A5,AA -> the leading 00 and FF are discarded; one write with wr_addr=15 and wr_data=0xA5.
REQ-040 SHALL cover: A5,01 followed by 255 cycles with in_valid=0 -> frame_err pulse, busy=0; a following full valid frame is written correctly.
REQ-041 SHALL cover: rst=0 asserted after A5,02 -> no wr_en, err_count=0; 256 forced errors -> err_count saturates at 255.
